// File: rtl/ram_arb_pkg.sv
// ram_arbiter shared types: FSM states, request bundle, master count.
// Default widths here match the ram_arbiter parameter defaults.
package ram_arb_pkg;

  localparam int NUM_MASTERS = 2;
  localparam int DATA_W      = 32;
  localparam int ADDR_W      = 31;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    CAPTURE,
    RESP
  } arb_state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/ram_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: on contention the master that did not
// win last time is granted; a lone requester always wins.
module rr_arbiter2
  import ram_arb_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] valid_i,
  input  logic                   last_grant_i,
  output logic [NUM_MASTERS-1:0] grant_o
);

  // One-hot grant from the two valids and the previous winner
  always_comb begin
    grant_o = '0;
    unique case (1'b1)
      (valid_i[0] & valid_i[1]):
        grant_o = last_grant_i ? 2'b01 : 2'b10;
      (valid_i[0] & ~valid_i[1]):
        grant_o = 2'b01;
      (~valid_i[0] & valid_i[1]):
        grant_o = 2'b10;
      default:
        grant_o = '0;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter for two masters, 4-cycle serialised access.
// RAM_ARB_FIXED_PRIO_EN selects fixed m0 priority instead of round-robin.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int RAM_WIDTH  = ADDR_W,
  parameter int RAM_DEPTH  = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req_valid,
  output logic                  m0_req_ready,
  input  logic                  m0_we,
  input  logic [RAM_WIDTH-1:0]  m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_rsp_valid,
  output logic                  m0_rsp_err,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req_valid,
  output logic                  m1_req_ready,
  input  logic                  m1_we,
  input  logic [RAM_WIDTH-1:0]  m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_rsp_valid,
  output logic                  m1_rsp_err,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [RAM_WIDTH-1:0]  ram_address,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam logic [RAM_WIDTH-1:0] DEPTH_W = RAM_WIDTH'(RAM_DEPTH);

  arb_state_t             state_q;
  req_t                   req_q;
  logic                   err_q;
  logic                   owner_q;
  logic                   ram_en_q;
  logic                   ram_we_q;
  logic [DATA_WIDTH-1:0]  rdata_q;
  logic [NUM_MASTERS-1:0] rsp_valid_q;
  logic [NUM_MASTERS-1:0] rsp_err_q;

  logic [NUM_MASTERS-1:0] valid;
  logic [NUM_MASTERS-1:0] grant;
  logic                   idle;
  logic                   hs;
  req_t                   sel_d;
  logic                   sel_err_d;

  assign valid = {m1_req_valid, m0_req_valid};

`ifdef RAM_ARB_FIXED_PRIO_EN
  // m0 always wins; m1 only when m0 is quiet
  always_comb begin
    grant = valid[0] ? 2'b01 : {valid[1], 1'b0};
  end
`else
  logic last_grant_q;

  rr_arbiter2 u_arb (
    .valid_i      (valid),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );
`endif

  assign idle = (state_q == IDLE);
  assign hs   = idle & (|grant);

  // Mux the winner's payload and range-check its address
  always_comb begin
    sel_d = '0;
    if (grant[1]) begin
      sel_d.we    = m1_we;
      sel_d.addr  = m1_addr;
      sel_d.wdata = m1_wdata;
    end else begin
      sel_d.we    = m0_we;
      sel_d.addr  = m0_addr;
      sel_d.wdata = m0_wdata;
    end
    sel_err_d = (sel_d.addr >= DEPTH_W);
  end

  assign m0_req_ready = idle & grant[0];
  assign m1_req_ready = idle & grant[1];

  assign ram_en      = ram_en_q;
  assign ram_we      = ram_we_q;
  assign ram_address = req_q.addr;
  assign ram_wdata   = req_q.wdata;

  assign m0_rsp_valid = rsp_valid_q[0];
  assign m1_rsp_valid = rsp_valid_q[1];
  assign m0_rsp_err   = rsp_err_q[0];
  assign m1_rsp_err   = rsp_err_q[1];
  assign m0_rdata     = owner_q ? '0 : rdata_q;
  assign m1_rdata     = owner_q ? rdata_q : '0;

  // Access sequencer: accept, strobe RAM, capture data, respond
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_q        <= '0;
      err_q        <= 1'b0;
      owner_q      <= 1'b0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      rdata_q      <= '0;
      rsp_valid_q  <= '0;
      rsp_err_q    <= '0;
`ifndef RAM_ARB_FIXED_PRIO_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (hs) begin
            owner_q  <= grant[1];
            req_q    <= sel_d;
            err_q    <= sel_err_d;
            ram_en_q <= ~sel_err_d;
            ram_we_q <= sel_d.we & ~sel_err_d;
`ifndef RAM_ARB_FIXED_PRIO_EN
            last_grant_q <= grant[1];
`endif
            state_q  <= ACCESS;
          end
        end
        ACCESS: begin
          ram_en_q <= 1'b0;
          ram_we_q <= 1'b0;
          state_q  <= CAPTURE;
        end
        CAPTURE: begin
          rdata_q     <= (!req_q.we && !err_q) ? ram_rdata : '0;
          rsp_valid_q <= {owner_q, ~owner_q};
          rsp_err_q   <= {owner_q & err_q, ~owner_q & err_q};
          state_q     <= RESP;
        end
        RESP: begin
          rsp_valid_q <= '0;
          rsp_err_q   <= '0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomised bench for ram_arbiter with a transaction-level model.
// Build with RAM_ARB_FIXED_PRIO_EN to check the fixed-priority variant.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req_valid, m0_req_ready, m0_we;
  logic [30:0] m0_addr;
  logic [31:0] m0_wdata;
  logic        m0_rsp_valid, m0_rsp_err;
  logic [31:0] m0_rdata;
  logic        m1_req_valid, m1_req_ready, m1_we;
  logic [30:0] m1_addr;
  logic [31:0] m1_wdata;
  logic        m1_rsp_valid, m1_rsp_err;
  logic [31:0] m1_rdata;
  logic        ram_en, ram_we;
  logic [30:0] ram_address;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = 32'h0;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  ram_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .m0_req_valid (m0_req_valid),
    .m0_req_ready (m0_req_ready),
    .m0_we        (m0_we),
    .m0_addr      (m0_addr),
    .m0_wdata     (m0_wdata),
    .m0_rsp_valid (m0_rsp_valid),
    .m0_rsp_err   (m0_rsp_err),
    .m0_rdata     (m0_rdata),
    .m1_req_valid (m1_req_valid),
    .m1_req_ready (m1_req_ready),
    .m1_we        (m1_we),
    .m1_addr      (m1_addr),
    .m1_wdata     (m1_wdata),
    .m1_rsp_valid (m1_rsp_valid),
    .m1_rsp_err   (m1_rsp_err),
    .m1_rdata     (m1_rdata),
    .ram_en       (ram_en),
    .ram_we       (ram_we),
    .ram_address  (ram_address),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_val(input int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic void chk(input string nm, input logic [63:0] act,
                              input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // RAM macro stand-in: synchronous read, junk on the bus otherwise
  logic [31:0] mem [256];
  bit          mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      mem_init <= 1'b1;
    end else if (ram_en === 1'b1) begin
      if (ram_we) mem[ram_address[7:0]] <= ram_wdata;
      else ram_rdata <= mem[ram_address[7:0]];
    end else begin
      ram_rdata <= $urandom;
    end
  end

  // Transaction-level reference model and compare process
  logic [31:0] refmem [256];
  bit          ref_init = 1'b0;
  int          last_hs = -1000;
  bit          lg = 1'b1;
  bit          pend_v = 1'b0;
  int          phc;
  bit          pown, pwe, perr;
  logic [30:0] paddr;
  logic [31:0] pwd, prd;
  int          w_m;
  bit          idle_m;
  bit          log_on = 1'b0;
  int          gq[$];
  int          gc[$];

  always @(negedge clk) begin
    if (!ref_init) begin
      for (int i = 0; i < 256; i++) refmem[i] = init_val(i);
      ref_init = 1'b1;
    end
    if (!rst_n) begin
      chk("rst_ram_en", ram_en, 0);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_ram_address", ram_address, 0);
      chk("rst_ram_wdata", ram_wdata, 0);
      chk("rst_m0_ready", m0_req_ready, 0);
      chk("rst_m1_ready", m1_req_ready, 0);
      chk("rst_m0_rsp_valid", m0_rsp_valid, 0);
      chk("rst_m1_rsp_valid", m1_rsp_valid, 0);
      chk("rst_m0_rsp_err", m0_rsp_err, 0);
      chk("rst_m1_rsp_err", m1_rsp_err, 0);
      chk("rst_m0_rdata", m0_rdata, 0);
      chk("rst_m1_rdata", m1_rdata, 0);
      pend_v  = 1'b0;
      last_hs = -1000;
      lg      = 1'b1;
    end else begin
      idle_m = (cyc - last_hs) >= 4;
      w_m = -1;
      if (idle_m) begin
        if (m0_req_valid && m1_req_valid) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
          w_m = 0;
`else
          w_m = lg ? 0 : 1;
`endif
        end else if (m0_req_valid) w_m = 0;
        else if (m1_req_valid) w_m = 1;
      end
      chk("m0_req_ready", m0_req_ready, w_m == 0);
      chk("m1_req_ready", m1_req_ready, w_m == 1);
      if (pend_v && cyc == phc + 1) begin
        chk("ram_en", ram_en, !perr);
        chk("ram_we", ram_we, pwe && !perr);
        if (!perr) begin
          chk("ram_address", ram_address, paddr);
          if (pwe) chk("ram_wdata", ram_wdata, pwd);
        end
      end else begin
        chk("ram_en_quiet", ram_en, 0);
      end
      if (pend_v && cyc == phc + 3) begin
        chk("m0_rsp_valid", m0_rsp_valid, pown == 0);
        chk("m1_rsp_valid", m1_rsp_valid, pown == 1);
        if (!pown) begin
          chk("m0_rsp_err", m0_rsp_err, perr);
          chk("m0_rdata", m0_rdata, prd);
        end else begin
          chk("m1_rsp_err", m1_rsp_err, perr);
          chk("m1_rdata", m1_rdata, prd);
        end
        pend_v = 1'b0;
      end else begin
        chk("m0_rsp_quiet", m0_rsp_valid, 0);
        chk("m1_rsp_quiet", m1_rsp_valid, 0);
      end
      if (w_m >= 0) begin
        pown  = (w_m == 1);
        pwe   = pown ? m1_we : m0_we;
        paddr = pown ? m1_addr : m0_addr;
        pwd   = pown ? m1_wdata : m0_wdata;
        perr  = paddr >= 31'd256;
        prd   = (pwe || perr) ? 32'h0 : refmem[paddr[7:0]];
        if (pwe && !perr) refmem[paddr[7:0]] = pwd;
        phc     = cyc;
        pend_v  = 1'b1;
        last_hs = cyc;
        lg      = pown;
        if (log_on) begin
          gq.push_back(w_m);
          gc.push_back(cyc);
        end
      end
    end
  end

  task automatic set_req(input bit m, input bit v, input bit we,
                         input logic [30:0] a, input logic [31:0] d);
    if (!m) begin
      m0_req_valid = v; m0_we = we; m0_addr = a; m0_wdata = d;
    end else begin
      m1_req_valid = v; m1_we = we; m1_addr = a; m1_wdata = d;
    end
  endtask

  // One request from master m; returns response and its latency
  task automatic req_rsp(input bit m, input bit we, input logic [30:0] a,
                         input logic [31:0] d, output bit err,
                         output logic [31:0] rd, output int lat);
    bit hs = 1'b0;
    int hc = 0;
    lat = -1; err = 1'b0; rd = 32'hx;
    @(posedge clk); #1;
    set_req(m, 1'b1, we, a, d);
    for (int i = 0; i < 40 && !hs; i++) begin
      @(negedge clk);
      if (m ? m1_req_ready : m0_req_ready) begin
        hs = 1'b1;
        hc = cyc;
      end
    end
    chk("handshake_seen", hs, 1);
    @(posedge clk); #1;
    set_req(m, 1'b0, $urandom_range(0, 1), 31'($urandom), $urandom);
    for (int i = 0; i < 10 && lat < 0; i++) begin
      @(negedge clk);
      if (m ? m1_rsp_valid : m0_rsp_valid) begin
        lat = cyc - hc;
        err = m ? m1_rsp_err : m0_rsp_err;
        rd  = m ? m1_rdata : m0_rdata;
      end
    end
  endtask

  function automatic logic [30:0] rand_addr();
    int r = $urandom_range(0, 9);
    if (r == 0) return 31'(256 + $urandom_range(0, 50));
    if (r == 1) return 31'd255;
    if (r == 2) return 31'($urandom);
    return 31'($urandom_range(0, 15));
  endfunction

  task automatic run_random(input int n);
    bit a0, a1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      a0 = m0_req_valid & m0_req_ready;
      a1 = m1_req_valid & m1_req_ready;
      @(posedge clk); #1;
      if (!m0_req_valid || a0)
        set_req(0, $urandom_range(0, 2) != 0, $urandom_range(0, 1),
                rand_addr(), $urandom);
      else if ($urandom_range(0, 15) == 0)
        m0_req_valid = 1'b0;
      if (!m1_req_valid || a1)
        set_req(1, $urandom_range(0, 2) != 0, $urandom_range(0, 1),
                rand_addr(), $urandom);
      else if ($urandom_range(0, 15) == 0)
        m1_req_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  bit          e;
  logic [31:0] rd;
  int          lat;
  int          n0;
  int          rsp_seen;
  bit          got;

  initial begin
    rst_n = 1'b0;
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // write then read back through m0
    req_rsp(0, 1'b1, 31'h10, 32'hDEADBEEF, e, rd, lat);
    chk("wr_latency", lat, 3);
    chk("wr_err", e, 0);
    chk("wr_rdata_zero", rd, 0);
    req_rsp(0, 1'b0, 31'h10, 32'h0, e, rd, lat);
    chk("rd_latency", lat, 3);
    chk("rd_err", e, 0);
    chk("rd_data", rd, 32'hDEADBEEF);

    // out-of-range and last legal address via m1
    req_rsp(1, 1'b0, 31'd256, 32'h0, e, rd, lat);
    chk("oor_latency", lat, 3);
    chk("oor_err", e, 1);
    chk("oor_rdata", rd, 0);
    req_rsp(1, 1'b0, 31'd255, 32'h0, e, rd, lat);
    chk("last_addr_err", e, 0);
    chk("last_addr_data", rd, init_val(255));

    // reset during CAPTURE of an m0 read
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b0, 31'h10, 32'h0);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = m0_req_ready;
    end
    chk("mid_rst_hs", got, 1);
    @(posedge clk); #1;
    m0_req_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_m0_rdata", m0_rdata, 0);
    chk("mid_rst_ram_en", ram_en, 0);
    chk("mid_rst_rsp", m0_rsp_valid, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    rsp_seen = 0;
    repeat (6) begin
      @(negedge clk);
      rsp_seen += int'(m0_rsp_valid) + int'(m1_rsp_valid);
    end
    chk("no_rsp_after_rst", rsp_seen, 0);

    // continuous contention: reads to 1 (m0) and 2 (m1)
    gq.delete();
    gc.delete();
    log_on = 1'b1;
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b0, 31'h1, 32'h0);
    set_req(1, 1'b1, 1'b0, 31'h2, 32'h0);
    for (int i = 0; i < 40 && gq.size() < 4; i++) @(negedge clk);
    chk("contend_grants", gq.size() >= 4, 1);
    if (gq.size() >= 4) begin
      chk("grant0", gq[0], 0);
`ifdef RAM_ARB_FIXED_PRIO_EN
      chk("grant1", gq[1], 0);
      chk("grant2", gq[2], 0);
      chk("grant3", gq[3], 0);
`else
      chk("grant1", gq[1], 1);
      chk("grant2", gq[2], 0);
      chk("grant3", gq[3], 1);
`endif
      chk("grant_spacing1", gc[1] - gc[0], 4);
      chk("grant_spacing2", gc[2] - gc[1], 4);
    end
    @(posedge clk); #1;
    m0_req_valid = 1'b0;
    n0 = gq.size();
    for (int i = 0; i < 12 && gq.size() <= n0; i++) @(negedge clk);
    chk("m1_after_m0_drop_seen", gq.size() > n0, 1);
    if (gq.size() > n0) chk("m1_after_m0_drop", gq[n0], 1);
    @(posedge clk); #1;
    m1_req_valid = 1'b0;
    log_on = 1'b0;
    repeat (6) @(posedge clk);

    // randomised traffic, with a reset in between
    run_random(1500);
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    do_reset();
    run_random(1500);
    @(posedge clk); #1;
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    repeat (8) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
